adder_prefix_pipe: RTL and testbench

//  Downstream consumer of adder_stage0. Takes per-bit generate/propagate vectors plus the
//  raw half-sum, runs a Kogge-Stone prefix carry tree and final sum XOR. Pipeline registers
//  sit between prefix levels. Valid/ready handshake on both sides; sideband tag carried.

---
 rtl/adder_prefix_pipe.sv | 145 ++++++++++++++
 tb/tb_adder_prefix_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_prefix_pipe.sv
// Pipelined Kogge-Stone carry tree and final sum stage fed by per-bit generate/propagate/half-sum.
// A register rank follows every REG_EVERY prefix levels, and the last rank holds sum, carry-out and tag.
module adder_prefix_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gen_in,
  input  logic [WIDTH-1:0] prop_in,
  input  logic [WIDTH-1:0] hsum_in,
  input  logic             cin_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTAGE = (LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic              advance;
  logic              load;
  logic [NSTAGE-1:0] valid_r;
  logic [TAG_W-1:0]  tag_r [NSTAGE];
  logic [WIDTH-1:0]  sum_s;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_s;
  logic              cout_r;

  // The whole pipe moves in lockstep; bubbles are not collapsed.
  assign out_valid = valid_r[NSTAGE-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign load      = advance & ~flush;

  assign sum_out  = sum_r;
  assign cout_out = cout_r;
  assign tag_out  = tag_r[NSTAGE-1];

  // Valid bits: flush clears every rank and overrides both load and shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (advance) begin
      valid_r <= NSTAGE'({valid_r, in_valid});
    end
  end

  // Tag sideband travels alongside the data ranks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTAGE; s++) begin
        tag_r[s] <= '0;
      end
    end else if (load) begin
      tag_r[0] <= tag_in;
      for (int s = 1; s < NSTAGE; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  // Final result rank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      sum_r  <= sum_s;
      cout_r <= cout_s;
    end
  end

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = ((s + 1) * REG_EVERY < LEVELS) ? (s + 1) * REG_EVERY : LEVELS;

    logic [WIDTH-1:0] g_i;
    logic [WIDTH-1:0] p_i;
    logic [WIDTH-1:0] h_i;
    logic             c_i;
    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;

    if (s == 0) begin : g_src
      assign g_i = gen_in;
      assign p_i = prop_in;
      assign h_i = hsum_in;
      assign c_i = cin_in;
    end else begin : g_src
      assign g_i = g_stage[s-1].g_rank.g_r;
      assign p_i = g_stage[s-1].g_rank.p_r;
      assign h_i = g_stage[s-1].g_rank.h_r;
      assign c_i = g_stage[s-1].g_rank.c_r;
    end

    // Prefix levels LO..HI-1: bit i absorbs bit i-2^k; bits below 2^k pass through.
    always_comb begin
      g_o = g_i;
      p_o = p_i;
      for (int k = LO; k < HI; k++) begin
        g_o = g_o | (p_o & (g_o << (1 << k)));
        p_o = p_o & ((p_o << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
      end
    end

    if (s < NSTAGE - 1) begin : g_rank
      logic [WIDTH-1:0] g_r;
      logic [WIDTH-1:0] p_r;
      logic [WIDTH-1:0] h_r;
      logic             c_r;

      // Intermediate rank: group G/P so far, plus half-sum and carry-in for the sum stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_r <= '0;
          p_r <= '0;
          h_r <= '0;
          c_r <= 1'b0;
        end else if (load) begin
          g_r <= g_o;
          p_r <= p_o;
          h_r <= h_i;
          c_r <= c_i;
        end
      end
    end else begin : g_final
      // Carry into bit i is group G over [i-1:0]; bit 0 takes the raw carry-in.
      always_comb begin
        sum_s  = h_i ^ {g_o[WIDTH-2:0], c_i};
        cout_s = g_o[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Self-checking bench for adder_prefix_pipe: directed latency/backpressure/flush/reset
// scenarios plus a randomized handshake run checked against plain A+B+cin arithmetic.
module tb_adder_prefix_pipe;

  localparam int LAT   = 3;
  localparam int NRAND = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] gen_in;
  logic [31:0] prop_in;
  logic [31:0] hsum_in;
  logic        cin_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic        cout_out;
  logic [3:0]  tag_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_prefix_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .gen_in(gen_in), .prop_in(prop_in), .hsum_in(hsum_in),
    .cin_in(cin_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .tag_out(tag_out)
  );

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic [3:0] t);
    gen_in     = a & b;
    prop_in    = a ^ b;
    gen_in[0]  = gen_in[0] | (prop_in[0] & c);
    hsum_in    = a ^ b;
    cin_in     = c;
    tag_in     = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_op(32'd0, 32'd0, 1'b0, 4'd0);
    #12;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (sum_out !== 32'd0) begin n_err++; $display("FAIL reset_sum got %h want 0", sum_out); end
    n_vec++; if (cout_out !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout_out); end
    n_vec++; if (tag_out !== 4'd0) begin n_err++; $display("FAIL reset_tag got %h want 0", tag_out); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 0) begin
        drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd5);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++; if (out_valid !== (j == LAT)) begin n_err++; $display("FAIL single_valid j=%0d got %b want %b", j, out_valid, (j == LAT)); end
      if (j == LAT) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== {4'd5, 1'b1, 32'd0})
          begin n_err++; $display("FAIL single_result got tag=%h c=%b s=%h want tag=5 c=1 s=0", tag_out, cout_out, sum_out); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic        c [4];
    logic [32:0] e [4];
    a = '{32'h1, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    b = '{32'h1, 32'h1,         32'h0, 32'hFFFF_FFFF};
    c = '{1'b0, 1'b0, 1'b1, 1'b0};
    e = '{{1'b0, 32'h2}, {1'b0, 32'h8000_0000}, {1'b0, 32'h1}, {1'b1, 32'hFFFF_FFFE}};
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      if (j < 4) begin
        drive_op(a[j], b[j], c[j], 4'(j));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++; if (out_valid !== (j >= LAT && j < LAT + 4)) begin n_err++; $display("FAIL b2b_valid j=%0d got %b", j, out_valid); end
      if (j >= LAT && j < LAT + 4) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== {4'(j - LAT), e[j-LAT]})
          begin n_err++; $display("FAIL b2b_result j=%0d got tag=%h c=%b s=%h want tag=%0d cs=%h", j, tag_out, cout_out, sum_out, j - LAT, e[j-LAT]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic        c [3];
    tick();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a[j] = $urandom; b[j] = $urandom; c[j] = 1'($urandom_range(1));
      drive_op(a[j], b[j], c[j], 4'(8 + j));
      in_valid = 1'b1;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready j=%0d got %b want 1", j, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_vec++; if ({in_ready, out_valid} !== 2'b01) begin n_err++; $display("FAIL bp_hold_hs h=%0d got ready=%b valid=%b want 0/1", h, in_ready, out_valid); end
      n_vec++; if ({tag_out, cout_out, sum_out} !== {4'd8, ref_add(a[0], b[0], c[0])})
        begin n_err++; $display("FAIL bp_hold_data h=%0d got tag=%h c=%b s=%h", h, tag_out, cout_out, sum_out); end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== (j < 3)) begin n_err++; $display("FAIL bp_drain_valid j=%0d got %b", j, out_valid); end
      if (j < 3) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== {4'(8 + j), ref_add(a[j], b[j], c[j])})
          begin n_err++; $display("FAIL bp_drain_data j=%0d got tag=%h c=%b s=%h", j, tag_out, cout_out, sum_out); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      drive_op($urandom, $urandom, 1'b0, 4'(j));
      in_valid = 1'b1;
      tick();
    end
    drive_op($urandom, $urandom, 1'b1, 4'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid j=%0d got %b want 0", j, out_valid); end
      tick();
    end
    a = $urandom; b = $urandom; c = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) begin
        drive_op(a, b, c, 4'd12);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++; if (out_valid !== (j == LAT)) begin n_err++; $display("FAIL flush_next_valid j=%0d got %b", j, out_valid); end
      if (j == LAT) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== {4'd12, ref_add(a, b, c)})
          begin n_err++; $display("FAIL flush_next_data got tag=%h c=%b s=%h", tag_out, cout_out, sum_out); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive_op($urandom | 32'h1, $urandom, 1'b1, 4'(j + 1));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({out_valid, cout_out, tag_out, sum_out, in_ready} !== {1'b0, 1'b0, 4'd0, 32'd0, 1'b1})
      begin n_err++; $display("FAIL rmid_reset got v=%b c=%b t=%h s=%h rdy=%b want 0/0/0/0/1", out_valid, cout_out, tag_out, sum_out, in_ready); end
    @(negedge clk);
    a = $urandom; b = $urandom; c = 1'b0;
    drive_op(a, b, c, 4'd7);
    in_valid = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== (k == LAT - 1)) begin n_err++; $display("FAIL rmid_after_valid k=%0d got %b", k, out_valid); end
      if (k == LAT - 1) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== {4'd7, ref_add(a, b, c)})
          begin n_err++; $display("FAIL rmid_after_data got tag=%h c=%b s=%h", tag_out, cout_out, sum_out); end
      end
    end
  endtask

  task automatic test_random();
    logic [36:0] exp_q [$];
    logic [36:0] exp_v;
    logic [36:0] prev_out;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [3:0]  t;
    logic        hold_prev;
    logic        accepted;
    int          issued;
    int          cycles;
    hold_prev = 1'b0;
    prev_out  = '0;
    issued    = 0;
    cycles    = 0;
    a = '0; b = '0; c = 1'b0; t = '0;
    tick();
    in_valid = 1'b0;
    while ((issued < NRAND || exp_q.size() != 0) && cycles < 60000) begin
      if (!in_valid && issued < NRAND && $urandom_range(1) == 1) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(1)); t = 4'($urandom);
        if ($urandom_range(7) == 0) b = ~a;
        drive_op(a, b, c, t);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (hold_prev) begin
        n_vec++; if ({tag_out, cout_out, sum_out} !== prev_out || out_valid !== 1'b1)
          begin n_err++; $display("FAIL rand_hold cyc=%0d got v=%b %h want 1 %h", cycles, out_valid, {tag_out, cout_out, sum_out}, prev_out); end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra cyc=%0d got result %h with nothing outstanding", cycles, {tag_out, cout_out, sum_out});
        end else begin
          exp_v = exp_q.pop_front();
          if ({tag_out, cout_out, sum_out} !== exp_v)
            begin n_err++; $display("FAIL rand_result cyc=%0d got %h want %h", cycles, {tag_out, cout_out, sum_out}, exp_v); end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {tag_out, cout_out, sum_out};
      accepted  = in_valid && in_ready;
      if (accepted) begin
        exp_q.push_back({t, ref_add(a, b, c)});
        issued++;
      end
      tick();
      cycles++;
      if (accepted) in_valid = 1'b0;
    end
    n_vec++;
    if (cycles >= 60000) begin
      n_err++; $display("FAIL rand_timeout issued=%0d outstanding=%0d want all %0d drained", issued, exp_q.size(), NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
